prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses framed words into program memory
// and holds the core in reset until a frame passes its checksum.
module prog_loader #(
    parameter logic [7:0] HEADER = 8'hA5,
    parameter int         DEPTH  = 64,
    localparam int        AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          nReset,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    output logic          pm_we,
    output logic [AW-1:0] pm_addr,
    output logic [12:0]   pm_wdata,
    output logic          cpu_nReset,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CHECK, S_DONE, S_ERR
    } state_t;

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    state_t      state, next_state;
    logic [AW:0] count;
    logic [4:0]  hi;
    logic [7:0]  acc;
    logic [AW:0] wl_inc;
    logic        fire;
    logic        last;

    assign fire   = rx_valid & rx_ready;
    assign wl_inc = words_loaded + 1'b1;
    assign last   = (wl_inc == count);

    // State register
    always_ff @(posedge clk) begin
        if (!nReset) state <= S_IDLE;
        else         state <= next_state;
    end

    // Next-state decode and per-state handshake/strobe outputs
    always_comb begin
        next_state = state;
        rx_ready   = 1'b1;
        pm_we      = 1'b0;
        busy       = 1'b0;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (fire && rx_data == HEADER) next_state = S_COUNT;
            end
            S_COUNT: begin
                busy = 1'b1;
                if (fire) begin
                    if (rx_data == 8'd0 || rx_data > DEPTH_B) next_state = S_ERR;
                    else                                      next_state = S_HI;
                end
            end
            S_HI: begin
                busy = 1'b1;
                if (fire) begin
                    if (rx_data[7:5] != 3'd0) next_state = S_ERR;
                    else                      next_state = S_LO;
                end
            end
            S_LO: begin
                busy = 1'b1;
                if (fire) next_state = S_WRITE;
            end
            S_WRITE: begin
                busy       = 1'b1;
                rx_ready   = 1'b0;
                pm_we      = 1'b1;
                next_state = last ? S_CHECK : S_HI;
            end
            S_CHECK: begin
                busy = 1'b1;
                if (fire) next_state = (rx_data == acc) ? S_DONE : S_ERR;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Frame datapath: checksum, word assembly, address and status flags
    always_ff @(posedge clk) begin
        if (!nReset) begin
            cpu_nReset   <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            pm_addr      <= '0;
            pm_wdata     <= '0;
            acc          <= '0;
            count        <= '0;
            hi           <= '0;
        end else begin
            if (next_state == S_ERR && state != S_ERR) error <= 1'b1;
            unique case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (fire && rx_data == HEADER) begin
                        cpu_nReset   <= 1'b0;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        pm_addr      <= '0;
                        acc          <= '0;
                    end
                end
                S_COUNT: begin
                    if (fire) begin
                        count <= rx_data[AW:0];
                        acc   <= acc ^ rx_data;
                    end
                end
                S_HI: begin
                    if (fire) begin
                        hi  <= rx_data[4:0];
                        acc <= acc ^ rx_data;
                    end
                end
                S_LO: begin
                    if (fire) begin
                        pm_wdata <= {hi, rx_data};
                        acc      <= acc ^ rx_data;
                    end
                end
                S_WRITE: begin
                    words_loaded <= wl_inc;
                    if (!last) pm_addr <= pm_addr + 1'b1;
                end
                S_CHECK: begin
                    if (fire && rx_data == acc) begin
                        done       <= 1'b1;
                        cpu_nReset <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
